// File: rtl/fpu_instr_decode.sv
// FPU front end: unpacks and classifies both operands, validates the opcode and
// resolves IEEE special cases into an early-out result over a 2-stage pipeline.
module fpu_instr_decode #(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned MAN_W     = 23,
    parameter bit          DENORM_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [1:0]               in_rmode,
    input  logic [EXP_W+MAN_W:0]     in_opa,
    input  logic [EXP_W+MAN_W:0]     in_opb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_op,
    output logic [1:0]               out_rmode,
    output logic                     out_sign_a,
    output logic                     out_sign_b,
    output logic [EXP_W-1:0]         out_exp_a,
    output logic [EXP_W-1:0]         out_exp_b,
    output logic [MAN_W:0]           out_man_a,
    output logic [MAN_W:0]           out_man_b,
    output logic [2:0]               out_class_a,
    output logic [2:0]               out_class_b,
    output logic                     out_special,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [2:0]               out_flags
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] C_ZERO = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_NORM = 3'd2;
    localparam logic [2:0] C_INF  = 3'd3;
    localparam logic [2:0] C_QNAN = 3'd4;
    localparam logic [2:0] C_SNAN = 3'd5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [2:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0)
            classify = (m == '0 || !DENORM_EN) ? C_ZERO : C_SUB;
        else if (&e)
            classify = (m == '0) ? C_INF : (m[MAN_W-1] ? C_QNAN : C_SNAN);
        else
            classify = C_NORM;
    endfunction

    function automatic logic [EXP_W-1:0] eff_exp(input logic [2:0] c, input logic [EXP_W-1:0] e);
        eff_exp = (c == C_SUB) ? EXP_W'(1) : e;
    endfunction

    // Hidden bit only for normals; flushed subnormals lose their fraction.
    function automatic logic [MAN_W:0] eff_man(input logic [2:0] c, input logic [MAN_W-1:0] m);
        eff_man = {c == C_NORM, (c == C_ZERO) ? MAN_W'(0) : m};
    endfunction

    function automatic logic [W-1:0] inf_val(input logic s);
        inf_val = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    logic                 v1_q, v1_d, v2_q, v2_d;
    logic [2:0]           op1_q, op1_d, op2_q, op2_d;
    logic [1:0]           rm1_q, rm1_d, rm2_q, rm2_d;
    logic                 sa1_q, sa1_d, sb1_q, sb1_d, sa2_q, sa2_d, sb2_q, sb2_d;
    logic [EXP_W-1:0]     ea1_q, ea1_d, eb1_q, eb1_d, ea2_q, ea2_d, eb2_q, eb2_d;
    logic [MAN_W:0]       ma1_q, ma1_d, mb1_q, mb1_d, ma2_q, ma2_d, mb2_q, mb2_d;
    logic [2:0]           ca1_q, ca1_d, cb1_q, cb1_d, ca2_q, ca2_d, cb2_q, cb2_d;
    logic                 sp2_q, sp2_d;
    logic [W-1:0]         res2_q, res2_d;
    logic [2:0]           flg2_q, flg2_d;

    logic                 adv1, adv2;
    logic [2:0]           cls_a_c, cls_b_c;
    logic                 spec_c;
    logic [W-1:0]         res_c;
    logic [2:0]           flg_c;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    assign cls_a_c = classify(in_opa[W-2:MAN_W], in_opa[MAN_W-1:0]);
    assign cls_b_c = classify(in_opb[W-2:MAN_W], in_opb[MAN_W-1:0]);

    // Special-case resolution on the S1 contents; sb1_q is already the effective sign of B.
    always_comb begin
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sx;
        spec_c = 1'b0;
        res_c  = '0;
        flg_c  = '0;
        nan_a  = (ca1_q == C_QNAN) || (ca1_q == C_SNAN);
        nan_b  = (cb1_q == C_QNAN) || (cb1_q == C_SNAN);
        inf_a  = (ca1_q == C_INF);
        inf_b  = (cb1_q == C_INF);
        zero_a = (ca1_q == C_ZERO);
        zero_b = (cb1_q == C_ZERO);
        sx     = sa1_q ^ sb1_q;
        if (op1_q[2]) begin
            spec_c = 1'b1; res_c = QNAN; flg_c[2] = 1'b1;
        end else if (nan_a || nan_b) begin
            spec_c = 1'b1; res_c = QNAN;
            flg_c[0] = (ca1_q == C_SNAN) || (cb1_q == C_SNAN);
        end else begin
            case (op1_q)
                OP_ADD, OP_SUB: begin
                    if (inf_a && inf_b && (sa1_q != sb1_q)) begin
                        spec_c = 1'b1; res_c = QNAN; flg_c[0] = 1'b1;
                    end else if (inf_a) begin
                        spec_c = 1'b1; res_c = inf_val(sa1_q);
                    end else if (inf_b) begin
                        spec_c = 1'b1; res_c = inf_val(sb1_q);
                    end
                end
                OP_MUL: begin
                    if ((zero_a && inf_b) || (inf_a && zero_b)) begin
                        spec_c = 1'b1; res_c = QNAN; flg_c[0] = 1'b1;
                    end else if (inf_a || inf_b) begin
                        spec_c = 1'b1; res_c = inf_val(sx);
                    end else if (zero_a || zero_b) begin
                        spec_c = 1'b1; res_c = {sx, {(W-1){1'b0}}};
                    end
                end
                OP_DIV: begin
                    if ((zero_a && zero_b) || (inf_a && inf_b)) begin
                        spec_c = 1'b1; res_c = QNAN; flg_c[0] = 1'b1;
                    end else if (zero_b && !inf_a) begin
                        spec_c = 1'b1; res_c = inf_val(sx); flg_c[1] = 1'b1;
                    end else if (inf_a) begin
                        spec_c = 1'b1; res_c = inf_val(sx);
                    end else if (zero_a || inf_b) begin
                        spec_c = 1'b1; res_c = {sx, {(W-1){1'b0}}};
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage next-state: each stage holds unless it advances.
    always_comb begin
        v1_d = v1_q; op1_d = op1_q; rm1_d = rm1_q; sa1_d = sa1_q; sb1_d = sb1_q;
        ea1_d = ea1_q; eb1_d = eb1_q; ma1_d = ma1_q; mb1_d = mb1_q; ca1_d = ca1_q; cb1_d = cb1_q;
        v2_d = v2_q; op2_d = op2_q; rm2_d = rm2_q; sa2_d = sa2_q; sb2_d = sb2_q;
        ea2_d = ea2_q; eb2_d = eb2_q; ma2_d = ma2_q; mb2_d = mb2_q; ca2_d = ca2_q; cb2_d = cb2_q;
        sp2_d = sp2_q; res2_d = res2_q; flg2_d = flg2_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                op1_d = in_op;
                rm1_d = in_rmode;
                sa1_d = in_opa[W-1];
                sb1_d = in_opb[W-1] ^ (in_op == OP_SUB);
                ca1_d = cls_a_c;
                cb1_d = cls_b_c;
                ea1_d = eff_exp(cls_a_c, in_opa[W-2:MAN_W]);
                eb1_d = eff_exp(cls_b_c, in_opb[W-2:MAN_W]);
                ma1_d = eff_man(cls_a_c, in_opa[MAN_W-1:0]);
                mb1_d = eff_man(cls_b_c, in_opb[MAN_W-1:0]);
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                op2_d = op1_q; rm2_d = rm1_q; sa2_d = sa1_q; sb2_d = sb1_q;
                ea2_d = ea1_q; eb2_d = eb1_q; ma2_d = ma1_q; mb2_d = mb1_q;
                ca2_d = ca1_q; cb2_d = cb1_q;
                sp2_d = spec_c; res2_d = res_c; flg2_d = flg_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; op1_q <= '0; rm1_q <= '0; sa1_q <= 1'b0; sb1_q <= 1'b0;
            ea1_q <= '0; eb1_q <= '0; ma1_q <= '0; mb1_q <= '0; ca1_q <= '0; cb1_q <= '0;
            v2_q <= 1'b0; op2_q <= '0; rm2_q <= '0; sa2_q <= 1'b0; sb2_q <= 1'b0;
            ea2_q <= '0; eb2_q <= '0; ma2_q <= '0; mb2_q <= '0; ca2_q <= '0; cb2_q <= '0;
            sp2_q <= 1'b0; res2_q <= '0; flg2_q <= '0;
        end else begin
            v1_q <= v1_d; op1_q <= op1_d; rm1_q <= rm1_d; sa1_q <= sa1_d; sb1_q <= sb1_d;
            ea1_q <= ea1_d; eb1_q <= eb1_d; ma1_q <= ma1_d; mb1_q <= mb1_d; ca1_q <= ca1_d; cb1_q <= cb1_d;
            v2_q <= v2_d; op2_q <= op2_d; rm2_q <= rm2_d; sa2_q <= sa2_d; sb2_q <= sb2_d;
            ea2_q <= ea2_d; eb2_q <= eb2_d; ma2_q <= ma2_d; mb2_q <= mb2_d; ca2_q <= ca2_d; cb2_q <= cb2_d;
            sp2_q <= sp2_d; res2_q <= res2_d; flg2_q <= flg2_d;
        end
    end

    assign out_valid   = v2_q;
    assign out_op      = op2_q;
    assign out_rmode   = rm2_q;
    assign out_sign_a  = sa2_q;
    assign out_sign_b  = sb2_q;
    assign out_exp_a   = ea2_q;
    assign out_exp_b   = eb2_q;
    assign out_man_a   = ma2_q;
    assign out_man_b   = mb2_q;
    assign out_class_a = ca2_q;
    assign out_class_b = cb2_q;
    assign out_special = sp2_q;
    assign out_result  = res2_q;
    assign out_flags   = flg2_q;

endmodule

// File: tb/tb_fpu_instr_decode.sv
// Directed bench for fpu_instr_decode: handshake/latency, stalls, classification and special cases.
module tb_fpu_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_rmode;
    logic [31:0] in_opa, in_opb;

    logic        in_ready, out_valid, out_sign_a, out_sign_b, out_special;
    logic [2:0]  out_op, out_class_a, out_class_b, out_flags;
    logic [1:0]  out_rmode;
    logic [7:0]  out_exp_a, out_exp_b;
    logic [23:0] out_man_a, out_man_b;
    logic [31:0] out_result;

    logic        d0_in_ready, d0_out_valid, d0_sign_a, d0_sign_b, d0_special;
    logic [2:0]  d0_op, d0_class_a, d0_class_b, d0_flags;
    logic [1:0]  d0_rmode;
    logic [7:0]  d0_exp_a, d0_exp_b;
    logic [23:0] d0_man_a, d0_man_b;
    logic [31:0] d0_result;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sp;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;
    vec_t vecs [16];

    always #5 clk = ~clk;

    fpu_instr_decode #(.EXP_W(8), .MAN_W(23), .DENORM_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rmode(in_rmode), .in_opa(in_opa), .in_opb(in_opb), .out_valid(out_valid),
        .out_ready(out_ready), .out_op(out_op), .out_rmode(out_rmode),
        .out_sign_a(out_sign_a), .out_sign_b(out_sign_b), .out_exp_a(out_exp_a),
        .out_exp_b(out_exp_b), .out_man_a(out_man_a), .out_man_b(out_man_b),
        .out_class_a(out_class_a), .out_class_b(out_class_b), .out_special(out_special),
        .out_result(out_result), .out_flags(out_flags)
    );

    fpu_instr_decode #(.EXP_W(8), .MAN_W(23), .DENORM_EN(1'b0)) u_ftz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready), .in_op(in_op),
        .in_rmode(in_rmode), .in_opa(in_opa), .in_opb(in_opb), .out_valid(d0_out_valid),
        .out_ready(out_ready), .out_op(d0_op), .out_rmode(d0_rmode),
        .out_sign_a(d0_sign_a), .out_sign_b(d0_sign_b), .out_exp_a(d0_exp_a),
        .out_exp_b(d0_exp_b), .out_man_a(d0_man_a), .out_man_b(d0_man_b),
        .out_class_a(d0_class_a), .out_class_b(d0_class_b), .out_special(d0_special),
        .out_result(d0_result), .out_flags(d0_flags)
    );

    // Issue one instruction into an otherwise idle pipe and stop where out_valid is seen.
    task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output bit tout, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_rmode = 2'd1; in_opa = a; in_opb = b; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        tout = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin tout = 1'b0; break; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_rmode = '0;
        in_opa = '0; in_opb = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if ({out_result, out_flags, out_special} !== 36'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {out_result, out_flags, out_special}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_add;
        bit tout; int lat;
        run_one(3'd0, 32'h3F800000, 32'h40000000, tout, lat);
        total++; if (tout !== 1'b0) begin bad++; $display("FAIL add_timeout got=%0b want=0", tout); end
        total++; if (lat != 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
        total++; if (out_class_a !== 3'd2 || out_class_b !== 3'd2) begin bad++; $display("FAIL add_class got=%0d/%0d want=2/2", out_class_a, out_class_b); end
        total++; if (out_man_a !== 24'h800000) begin bad++; $display("FAIL add_man_a got=%h want=800000", out_man_a); end
        total++; if (out_exp_a !== 8'h7F || out_exp_b !== 8'h80) begin bad++; $display("FAIL add_exp got=%h/%h want=7f/80", out_exp_a, out_exp_b); end
        total++; if ({out_special, out_result, out_flags} !== 36'h0) begin bad++; $display("FAIL add_special got=%h want=0", {out_special, out_result, out_flags}); end
        total++; if (out_rmode !== 2'd1 || out_op !== 3'd0) begin bad++; $display("FAIL add_passthru got=%0d/%0d want=1/0", out_rmode, out_op); end
    endtask

    task automatic test_back_to_back;
        int idx = 0, got = 0, first = -1, last = -1;
        logic [7:0] seen [8];
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            in_valid = (idx < 8); in_op = 3'd0; in_opa = {1'b0, 8'(8'h70 + idx), 23'h0};
            in_opb = 32'h3F800000; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (got < 8) seen[got] = out_exp_a;
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
        total++; if (last - first != 7) begin bad++; $display("FAIL b2b_consecutive got=%0d want=7", last - first); end
        for (int k = 0; k < 8; k++) begin
            total++; if (seen[k] !== 8'(8'h70 + k)) begin bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", k, seen[k], 8'(8'h70 + k)); end
        end
    endtask

    task automatic test_stall;
        int idx = 0, got = 0;
        logic [7:0] seen [8];
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 5);
            in_valid = (idx < 6); in_op = 3'd0; in_opa = {1'b0, 8'(8'h90 + idx), 23'h0};
            in_opb = 32'h3F800000;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                total++; if (out_valid !== 1'b1 || out_exp_a !== 8'h90) begin bad++; $display("FAIL stall_frozen[%0d] got=%0b/%h want=1/90", cyc, out_valid, out_exp_a); end
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%0b want=0", cyc, in_ready); end
            end
            if (cyc == 4) begin
                total++; if (idx != 2) begin bad++; $display("FAIL stall_accepts got=%0d want=2", idx); end
            end
            if (out_valid && out_ready) begin
                if (got < 8) seen[got] = out_exp_a;
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        total++; if (got != 6) begin bad++; $display("FAIL stall_count got=%0d want=6", got); end
        for (int k = 0; k < 6; k++) begin
            total++; if (seen[k] !== 8'(8'h90 + k)) begin bad++; $display("FAIL stall_order[%0d] got=%h want=%h", k, seen[k], 8'(8'h90 + k)); end
        end
    endtask

    task automatic test_specials;
        bit tout; int lat;
        vecs[0]  = '{3'd3, 32'h3F800000, 32'h80000000, 1'b1, 32'hFF800000, 3'b010};
        vecs[1]  = '{3'd3, 32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 3'b001};
        vecs[2]  = '{3'd0, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 3'b001};
        vecs[3]  = '{3'd1, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000};
        vecs[4]  = '{3'd2, 32'h00000000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001};
        vecs[5]  = '{3'd0, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b001};
        vecs[6]  = '{3'd5, 32'h3F800000, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b100};
        vecs[7]  = '{3'd2, 32'h40000000, 32'h40400000, 1'b0, 32'h00000000, 3'b000};
        vecs[8]  = '{3'd2, 32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 3'b000};
        vecs[9]  = '{3'd3, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001};
        vecs[10] = '{3'd3, 32'h3F800000, 32'h7F800000, 1'b1, 32'h00000000, 3'b000};
        vecs[11] = '{3'd0, 32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b000};
        vecs[12] = '{3'd2, 32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, 3'b000};
        vecs[13] = '{3'd0, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000};
        vecs[14] = '{3'd3, 32'hFF800000, 32'h00000000, 1'b1, 32'hFF800000, 3'b000};
        vecs[15] = '{3'd7, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b100};
        for (int i = 0; i < 16; i++) begin
            run_one(vecs[i].op, vecs[i].a, vecs[i].b, tout, lat);
            total++; if (tout !== 1'b0) begin bad++; $display("FAIL spec_timeout[%0d] got=%0b want=0", i, tout); end
            total++; if (out_special !== vecs[i].sp) begin bad++; $display("FAIL spec_special[%0d] got=%0b want=%0b", i, out_special, vecs[i].sp); end
            total++; if (out_result !== vecs[i].res) begin bad++; $display("FAIL spec_result[%0d] got=%h want=%h", i, out_result, vecs[i].res); end
            total++; if (out_flags !== vecs[i].fl) begin bad++; $display("FAIL spec_flags[%0d] got=%b want=%b", i, out_flags, vecs[i].fl); end
        end
    endtask

    task automatic test_classify;
        bit tout; int lat;
        run_one(3'd0, 32'h00000001, 32'h7FC00000, tout, lat);
        total++; if (tout !== 1'b0) begin bad++; $display("FAIL cls_timeout got=%0b want=0", tout); end
        total++; if (out_class_a !== 3'd1 || out_exp_a !== 8'h01 || out_man_a !== 24'h000001) begin bad++; $display("FAIL cls_sub got=%0d/%h/%h want=1/01/000001", out_class_a, out_exp_a, out_man_a); end
        total++; if (out_class_b !== 3'd4) begin bad++; $display("FAIL cls_qnan got=%0d want=4", out_class_b); end
        total++; if (d0_class_a !== 3'd0 || d0_exp_a !== 8'h00 || d0_man_a !== 24'h0) begin bad++; $display("FAIL cls_ftz got=%0d/%h/%h want=0/00/000000", d0_class_a, d0_exp_a, d0_man_a); end
        run_one(3'd1, 32'h7F800000, 32'hFF800001, tout, lat);
        total++; if (out_class_a !== 3'd3 || out_class_b !== 3'd5) begin bad++; $display("FAIL cls_inf_snan got=%0d/%0d want=3/5", out_class_a, out_class_b); end
        total++; if (out_sign_a !== 1'b0 || out_sign_b !== 1'b0) begin bad++; $display("FAIL cls_sub_sign got=%0b/%0b want=0/0", out_sign_a, out_sign_b); end
    endtask

    task automatic test_reset_midop;
        bit tout; int lat;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd3;
            in_opa = 32'h3F800000; in_opb = 32'h80000000;
        end
        #1;
        total++; if (out_valid !== 1'b1 || out_special !== 1'b1) begin bad++; $display("FAIL rmid_full got=%0b/%0b want=1/1", out_valid, out_special); end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", out_valid); end
        total++; if ({out_result, out_flags, out_special, out_op} !== 39'h0) begin bad++; $display("FAIL rmid_outputs got=%h want=0", {out_result, out_flags, out_special, out_op}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%0b want=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_one(3'd0, 32'h3F800000, 32'h40000000, tout, lat);
        total++; if (tout !== 1'b0 || lat != 2) begin bad++; $display("FAIL rmid_latency got=%0b/%0d want=0/2", tout, lat); end
        total++; if (out_exp_b !== 8'h80 || out_special !== 1'b0 || out_op !== 3'd0) begin bad++; $display("FAIL rmid_new got=%h/%0b/%0d want=80/0/0", out_exp_b, out_special, out_op); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_specials();
        test_classify();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_instr_decode.md
Name: fpu_instr_decode

Overview:
- Parametrised, pipelined front end of the FPU: accepts one packed instruction per cycle (opcode, rounding mode, two IEEE-754-style operands of configurable exponent/mantissa width).
- Unpacks and classifies both operands, validates the opcode, and resolves IEEE special cases (NaN, Inf, zero, divide-by-zero) into an early-out result.
- Sits between the instruction source and the add/sub/mul/div datapaths. Uses valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored mantissa field width (≥2).
- DENORM_EN, 1: 1 means subnormals are classified as SUB; 0 means flush to zero (classified ZERO, sign kept).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  instruction valid
- in_ready  out  1  decoder can accept
- in_op  in  3  0=ADD 1=SUB 2=MULT 3=DIV; 4–7 illegal
- in_rmode  in  2  0=nearest_even 1=to_zero 2=up 3=down
- in_opa  in  1+EXP_W+MAN_W  operand A {sign, exponent, mantissa}
- in_opb  in  1+EXP_W+MAN_W  operand B
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_op  out  3  opcode passthrough
- out_rmode  out  2  rmode passthrough
- out_sign_a, out_sign_b  out  1  operand signs; for SUB, out_sign_b is inverted
- out_exp_a, out_exp_b  out  EXP_W  effective biased exponent (SUB class → 1)
- out_man_a, out_man_b  out  MAN_W+1  significand with hidden bit (NORM → 1, SUB/ZERO → 0)
- out_class_a, out_class_b  out  3  0=ZERO 1=SUB 2=NORM 3=INF 4=QNAN 5=SNAN
- out_special  out  1  out_result is final; datapath bypassed
- out_result  out  1+EXP_W+MAN_W  early-out result (0 when !out_special)
- out_flags  out  3  {illegal_op, divzero, invalid}

Behaviour:
Structure and handshake:
- Two register stages. S1 registers the unpack and classification. S2 registers special-case resolution, flags, and outputs.
- Latency is 2 cycles from in_valid&&in_ready to out_valid. Throughput is 1 per cycle under continuous out_ready.
- Stage advance rules:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - in_ready = adv1
- An S2 entry is held stable (all outputs frozen) while out_valid && !out_ready.
- No bubbles are inserted: a full pipeline with out_ready=1 accepts every cycle. No combinational path from in_valid to out_valid.

Reset:
- On rst, v1 = v2 = 0 and every output register is 0. After reset, in_ready = 1.
- Reset mid-operation discards in-flight entries; no partial output is produced.

Classification (E = exponent field, M = mantissa field):
- E=0, M=0 → ZERO
- E=0, M≠0 → SUB (DENORM_EN=1) or ZERO (DENORM_EN=0, mantissa forced to 0)
- E all ones, M=0 → INF
- E all ones, M MSB=1 → QNAN
- E all ones, M MSB=0 and M≠0 → SNAN
- Otherwise → NORM

Special-case resolution (priority top-down). The canonical qNaN is sign 0, exponent all ones, mantissa = 1 followed by MAN_W−1 zeros.
1. op ≥ 4 → special, result qNaN, illegal_op=1.
2. Either operand NaN → special, result qNaN; invalid=1 if either operand is SNAN.
3. ADD/SUB using the effective sign of B:
   - INF with opposite-sign INF → qNaN, invalid.
   - Otherwise any INF → that INF with its effective sign.
4. MULT:
   - ZERO×INF → qNaN, invalid.
   - INF × anything → INF.
   - ZERO × finite → ZERO.
   - Result sign = sign_a XOR sign_b.
5. DIV (result sign = XOR of signs):
   - ZERO/ZERO or INF/INF → qNaN, invalid.
   - finite nonzero / ZERO → INF, divzero.
   - INF/x → INF.
   - ZERO/x or x/INF → ZERO.
6. Otherwise out_special=0, out_result=0, flags=0.

Additional rules:
- ADD/SUB with zero operands is not special; the datapath handles zero-sign rules.
- out_flags are valid only with out_valid.

Test Plan:
- Reset then single ADD, A=0x3F800000, B=0x40000000 → two cycles later out_valid=1, out_class_a/b=NORM, out_man_a=0x800000, out_exp_b=0x80, out_special=0.
- 8 back-to-back instructions with out_ready=1 → 8 consecutive out_valid cycles, order preserved. Then out_ready=0 for 3 cycles → outputs frozen, in_ready low after 2 further accepts, no loss or duplication.
- DIV A=0x3F800000, B=0x80000000 → out_special=1, out_result=0xFF800000, flags=3'b010. DIV 0/0 → result 0x7FC00000, flags=3'b001.
- ADD 0x7F800000 + 0xFF800000 → 0x7FC00000 invalid. SUB with the same operands → 0x7F800000, no flags. MULT 0x00000000 × 0x7F800000 → qNaN invalid.
- Operand 0x7F800001 (SNAN) + 1.0 → qNaN, invalid=1. in_op=5 → qNaN, flags=3'b100. Operand A=0x00000001: with DENORM_EN=1 → class SUB, exp 1, man 0x000001; with DENORM_EN=0 → class ZERO.
- Assert rst with both stages full → out_valid=0 and outputs 0 immediately (asynchronous). After deassert, the first new instruction emerges after 2 cycles.
